// File: rtl/game_ctrl.sv
// Per-frame game sequencer: frame strobe/timer, debounced jump request, score/speed ramp and IDLE/PLAY/OVER flow.
// Define GAME_CTRL_ACCEL_EN to build the speed ramp; otherwise speed is fixed at SPEED_INIT.
module game_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SPEED_INIT      = 6,
  parameter int SPEED_MAX       = 13,
  parameter int ACCEL_FRAMES    = 600,
  parameter int SCORE_DIV       = 6,
  parameter int RESTART_FRAMES  = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        btn_jump,
  input  logic        collision,
  output logic        update,
  output logic [5:0]  timer,
  output logic [4:0]  speed,
  output logic        jump,
  output logic        crash,
  output logic        game_rst,
  output logic [13:0] score,
  output logic [1:0]  game_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_OVER = 2'd2} state_t;

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SDW = $clog2(SCORE_DIV + 1);
  localparam int HW  = $clog2(RESTART_FRAMES + 1);
  localparam logic [13:0] SCORE_MAX = 14'd9999;

  logic           tick_q, tick_d, tick_prev_q, tick_prev_d, update_q, update_d;
  logic [5:0]     timer_q, timer_d;
  logic           sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           db_q, db_d, db_prev_q, db_prev_d;
  state_t         state_q, state_d;
  logic           jump_q, jump_d, crash_q, crash_d, game_rst_q, game_rst_d;
  logic [13:0]    score_q, score_d;
  logic [SDW-1:0] sdiv_q, sdiv_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic           press, play_step;

  always_comb begin
    tick_d      = frame_tick;
    tick_prev_d = tick_q;
    update_d    = tick_q & ~tick_prev_q;
    timer_d     = timer_q;
    if (update_q) timer_d = (timer_q == 6'd59) ? 6'd0 : timer_q + 6'd1;

    // Debounce: count consecutive disagreeing cycles, flip once the run is long enough.
    sync1_d   = btn_jump;
    sync2_d   = sync1_q;
    db_cnt_d  = '0;
    db_d      = db_q;
    db_prev_d = db_q;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) db_d = ~db_q;
      else db_cnt_d = db_cnt_q + 1'b1;
    end
    press = db_q & ~db_prev_q;

    state_d    = state_q;
    jump_d     = jump_q;
    crash_d    = crash_q;
    game_rst_d = 1'b0;
    score_d    = score_q;
    sdiv_d     = sdiv_q;
    hold_d     = hold_q;
    play_step  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (press) begin
          jump_d  = 1'b1;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (collision) begin
          crash_d = 1'b1;
          jump_d  = 1'b0;
          state_d = S_OVER;
        end else begin
          // A press in the update cycle wins, so the request survives into the next frame.
          if (press) jump_d = 1'b1;
          else if (update_q) jump_d = 1'b0;
          if (update_q) begin
            play_step = 1'b1;
            if (sdiv_q == SDW'(SCORE_DIV - 1)) begin
              sdiv_d = '0;
              if (score_q != SCORE_MAX) score_d = score_q + 14'd1;
            end else begin
              sdiv_d = sdiv_q + 1'b1;
            end
          end
        end
      end
      S_OVER: begin
        crash_d = 1'b1;
        jump_d  = 1'b0;
        if (update_q && hold_q != HW'(RESTART_FRAMES)) hold_d = hold_q + 1'b1;
        if (press && hold_q == HW'(RESTART_FRAMES)) begin
          game_rst_d = 1'b1;
          state_d    = S_IDLE;
          crash_d    = 1'b0;
          score_d    = '0;
          sdiv_d     = '0;
          hold_d     = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= 1'b0; tick_prev_q <= 1'b0; update_q <= 1'b0; timer_q <= '0;
      sync1_q <= 1'b0; sync2_q <= 1'b0; db_cnt_q <= '0; db_q <= 1'b0; db_prev_q <= 1'b0;
      state_q <= S_IDLE; jump_q <= 1'b0; crash_q <= 1'b0; game_rst_q <= 1'b0;
      score_q <= '0; sdiv_q <= '0; hold_q <= '0;
    end else begin
      tick_q <= tick_d; tick_prev_q <= tick_prev_d; update_q <= update_d; timer_q <= timer_d;
      sync1_q <= sync1_d; sync2_q <= sync2_d; db_cnt_q <= db_cnt_d; db_q <= db_d; db_prev_q <= db_prev_d;
      state_q <= state_d; jump_q <= jump_d; crash_q <= crash_d; game_rst_q <= game_rst_d;
      score_q <= score_d; sdiv_q <= sdiv_d; hold_q <= hold_d;
    end
  end

`ifdef GAME_CTRL_ACCEL_EN
  localparam int AW = $clog2(ACCEL_FRAMES + 1);
  logic [AW-1:0] accel_q, accel_d;
  logic [4:0]    speed_q, speed_d;

  always_comb begin
    accel_d = accel_q;
    speed_d = speed_q;
    if (game_rst_d) begin
      accel_d = '0;
      speed_d = 5'(SPEED_INIT);
    end else if (play_step) begin
      if (accel_q == AW'(ACCEL_FRAMES - 1)) begin
        accel_d = '0;
        if (speed_q < 5'(SPEED_MAX)) speed_d = speed_q + 5'd1;
      end else begin
        accel_d = accel_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      accel_q <= '0;
      speed_q <= 5'(SPEED_INIT);
    end else begin
      accel_q <= accel_d;
      speed_q <= speed_d;
    end
  end

  assign speed = speed_q;
`else
  assign speed = 5'(SPEED_INIT);
`endif

  assign update     = update_q;
  assign timer      = timer_q;
  assign jump       = jump_q;
  assign crash      = crash_q;
  assign game_rst   = game_rst_q;
  assign score      = score_q;
  assign game_state = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed self-checking bench for game_ctrl with small debounce/divider parameters.
module tb_game_ctrl;
  logic        clk = 1'b0;
  logic        rst, frame_tick, btn_jump, collision;
  logic        update, jump, crash, game_rst;
  logic [5:0]  timer;
  logic [4:0]  speed;
  logic [13:0] score;
  logic [1:0]  game_state;

  int tests = 0;
  int fails = 0;
  int upd_cnt = 0;
  int grst_cnt = 0;

`ifdef GAME_CTRL_ACCEL_EN
  localparam int EXP_SPEED9 = 9;
`else
  localparam int EXP_SPEED9 = 6;
`endif

  always #5 clk = ~clk;

  game_ctrl #(
    .DEBOUNCE_CYCLES(4), .SPEED_INIT(6), .SPEED_MAX(13),
    .ACCEL_FRAMES(3), .SCORE_DIV(2), .RESTART_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .btn_jump(btn_jump),
    .collision(collision), .update(update), .timer(timer), .speed(speed),
    .jump(jump), .crash(crash), .game_rst(game_rst), .score(score),
    .game_state(game_state)
  );

  always @(negedge clk) begin
    if (update === 1'b1) upd_cnt++;
    if (game_rst === 1'b1) grst_cnt++;
  end

  // Called at a negedge; returns at a negedge with the update pulse finished.
  task automatic pulse_frame(input int width);
    frame_tick = 1'b1;
    repeat (width) @(negedge clk);
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic press_btn();
    btn_jump = 1'b1;
    repeat (10) @(negedge clk);
    btn_jump = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; frame_tick = 1'b0; btn_jump = 1'b0; collision = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (update !== 1'b0) begin fails++; $display("FAIL rst_update got %0d exp 0", update); end
    tests++; if (timer !== 6'd0) begin fails++; $display("FAIL rst_timer got %0d exp 0", timer); end
    tests++; if (speed !== 5'd6) begin fails++; $display("FAIL rst_speed got %0d exp 6", speed); end
    tests++; if (jump !== 1'b0) begin fails++; $display("FAIL rst_jump got %0d exp 0", jump); end
    tests++; if (crash !== 1'b0) begin fails++; $display("FAIL rst_crash got %0d exp 0", crash); end
    tests++; if (game_rst !== 1'b0) begin fails++; $display("FAIL rst_game_rst got %0d exp 0", game_rst); end
    tests++; if (score !== 14'd0) begin fails++; $display("FAIL rst_score got %0d exp 0", score); end
    tests++; if (game_state !== 2'd0) begin fails++; $display("FAIL rst_state got %0d exp 0", game_state); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame();
    upd_cnt = 0;
    frame_tick = 1'b1;
    @(negedge clk);
    tests++; if (update !== 1'b0) begin fails++; $display("FAIL upd_early got %0d exp 0", update); end
    frame_tick = 1'b0;
    @(negedge clk);
    tests++; if (update !== 1'b1) begin fails++; $display("FAIL upd_latency got %0d exp 1", update); end
    @(negedge clk);
    tests++; if (update !== 1'b0) begin fails++; $display("FAIL upd_width got %0d exp 0", update); end
    @(negedge clk);
    pulse_frame(5);
    repeat (3) pulse_frame(1);
    tests++; if (upd_cnt !== 5) begin fails++; $display("FAIL upd_count got %0d exp 5", upd_cnt); end
    tests++; if (timer !== 6'd5) begin fails++; $display("FAIL timer5 got %0d exp 5", timer); end
    repeat (55) pulse_frame(1);
    tests++; if (timer !== 6'd0) begin fails++; $display("FAIL timer_wrap got %0d exp 0", timer); end
  endtask

  task automatic test_button();
    btn_jump = 1'b1;
    repeat (3) @(negedge clk);
    btn_jump = 1'b0;
    repeat (10) @(negedge clk);
    tests++; if (jump !== 1'b0) begin fails++; $display("FAIL short_press_jump got %0d exp 0", jump); end
    tests++; if (game_state !== 2'd0) begin fails++; $display("FAIL short_press_state got %0d exp 0", game_state); end
    btn_jump = 1'b1;
    repeat (6) @(negedge clk);
    tests++; if (jump !== 1'b0) begin fails++; $display("FAIL jump_edge6 got %0d exp 0", jump); end
    @(negedge clk);
    tests++; if (jump !== 1'b1) begin fails++; $display("FAIL jump_edge7 got %0d exp 1", jump); end
    tests++; if (game_state !== 2'd1) begin fails++; $display("FAIL play_state got %0d exp 1", game_state); end
    repeat (3) @(negedge clk);
    btn_jump = 1'b0;
    repeat (10) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    tests++; if (jump !== 1'b1 || update !== 1'b1) begin fails++; $display("FAIL jump_in_update got jump=%0d upd=%0d exp 1/1", jump, update); end
    @(negedge clk);
    tests++; if (jump !== 1'b0) begin fails++; $display("FAIL jump_clear got %0d exp 0", jump); end
    @(negedge clk);
  endtask

  task automatic test_speed_score();
    // one PLAY update already happened in test_button
    repeat (8) pulse_frame(1);
    tests++; if (score !== 14'd4) begin fails++; $display("FAIL score9 got %0d exp 4", score); end
    tests++; if (speed !== 5'(EXP_SPEED9)) begin fails++; $display("FAIL speed9 got %0d exp %0d", speed, EXP_SPEED9); end
  endtask

  task automatic test_collision();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    collision = 1'b1;
    tests++; if (update !== 1'b1 || crash !== 1'b0) begin fails++; $display("FAIL coll_setup got upd=%0d crash=%0d exp 1/0", update, crash); end
    @(negedge clk);
    collision = 1'b0;
    tests++; if (crash !== 1'b1) begin fails++; $display("FAIL coll_crash got %0d exp 1", crash); end
    tests++; if (game_state !== 2'd2) begin fails++; $display("FAIL coll_state got %0d exp 2", game_state); end
    tests++; if (score !== 14'd4) begin fails++; $display("FAIL coll_score got %0d exp 4", score); end
    repeat (3) @(negedge clk);
    tests++; if (crash !== 1'b1) begin fails++; $display("FAIL crash_hold got %0d exp 1", crash); end
  endtask

  task automatic test_restart();
    grst_cnt = 0;
    pulse_frame(1);
    press_btn();
    tests++; if (game_state !== 2'd2) begin fails++; $display("FAIL early_press_state got %0d exp 2", game_state); end
    tests++; if (grst_cnt !== 0) begin fails++; $display("FAIL early_press_grst got %0d exp 0", grst_cnt); end
    pulse_frame(1);
    btn_jump = 1'b1;
    repeat (6) @(negedge clk);
    tests++; if (game_rst !== 1'b0) begin fails++; $display("FAIL grst_early got %0d exp 0", game_rst); end
    @(negedge clk);
    tests++; if (game_rst !== 1'b1) begin fails++; $display("FAIL grst_pulse got %0d exp 1", game_rst); end
    tests++; if (game_state !== 2'd0) begin fails++; $display("FAIL restart_state got %0d exp 0", game_state); end
    tests++; if (score !== 14'd0) begin fails++; $display("FAIL restart_score got %0d exp 0", score); end
    tests++; if (speed !== 5'd6) begin fails++; $display("FAIL restart_speed got %0d exp 6", speed); end
    tests++; if (crash !== 1'b0) begin fails++; $display("FAIL restart_crash got %0d exp 0", crash); end
    @(negedge clk);
    tests++; if (game_rst !== 1'b0) begin fails++; $display("FAIL grst_width got %0d exp 0", game_rst); end
    repeat (2) @(negedge clk);
    btn_jump = 1'b0;
    repeat (12) @(negedge clk);
    tests++; if (grst_cnt !== 1) begin fails++; $display("FAIL grst_count got %0d exp 1", grst_cnt); end
    tests++; if (jump !== 1'b0) begin fails++; $display("FAIL restart_jump got %0d exp 0", jump); end
  endtask

  task automatic test_rst_mid();
    press_btn();
    pulse_frame(1);
    pulse_frame(1);
    collision = 1'b1;
    @(negedge clk);
    collision = 1'b0;
    tests++; if (game_state !== 2'd2 || score !== 14'd1) begin fails++; $display("FAIL pre_rst got state=%0d score=%0d exp 2/1", game_state, score); end
    btn_jump = 1'b1;
    repeat (4) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    rst = 1'b1; btn_jump = 1'b0; frame_tick = 1'b0;
    @(negedge clk);
    tests++; if (update !== 1'b0) begin fails++; $display("FAIL mid_update got %0d exp 0", update); end
    tests++; if (timer !== 6'd0) begin fails++; $display("FAIL mid_timer got %0d exp 0", timer); end
    tests++; if (speed !== 5'd6) begin fails++; $display("FAIL mid_speed got %0d exp 6", speed); end
    tests++; if (jump !== 1'b0 || crash !== 1'b0 || game_rst !== 1'b0) begin fails++; $display("FAIL mid_flags got j=%0d c=%0d g=%0d exp 0/0/0", jump, crash, game_rst); end
    tests++; if (score !== 14'd0) begin fails++; $display("FAIL mid_score got %0d exp 0", score); end
    tests++; if (game_state !== 2'd0) begin fails++; $display("FAIL mid_state got %0d exp 0", game_state); end
    rst = 1'b0;
    repeat (12) @(negedge clk);
    tests++; if (game_state !== 2'd0 || jump !== 1'b0) begin fails++; $display("FAIL mid_debounce got state=%0d jump=%0d exp 0/0", game_state, jump); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_frame();
    test_button();
    test_speed_score();
    test_collision();
    test_restart();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
